edge_pulse_bank: RTL
====================

Name: edge_pulse_bank

Overview:
- Multi-channel successor to the single-bit edge-to-pulse converter.
- Each channel takes an asynchronous switch or button input and passes it through a synchronizer and a debouncer, then produces a one-cycle pulse on the edges its mode selects.
- Each channel also keeps a sticky event flag with a clear handshake and an overrun flag.
- The bank sits between the board switches/keys and the lab datapath/FSM controllers.

Parameters:
- N_CH, 4: number of independent channels.
- SYNC_STAGES, 2: flip-flops in each input synchronizer; legal range 2..4.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before the debounced level changes; 0 and 1 are equivalent (no filtering beyond one cycle).
- REPEAT_DELAY, 1000: cycles from the rising debounced level to the first auto-repeat pulse (optional feature only).
- REPEAT_PERIOD, 250: cycles between subsequent auto-repeat pulses (optional feature only).

Ports:
- clk  input  1  system clock.
- rstN  input  1  reset, asynchronous, active-low.
- in  input  N_CH  raw asynchronous channel inputs.
- mode  input  2*N_CH  per-channel mode; bits [2i+1:2i] belong to channel i.
  - 00 rise, 01 fall, 10 both edges, 11 channel disabled.
- clr  input  N_CH  per-channel clear for the event and overrun flags; level-sensitive, sampled each clk.
- pulse  output  N_CH  one-cycle pulse per qualifying edge.
- level  output  N_CH  debounced, synchronized input level.
- event_flag  output  N_CH  sticky: set by pulse, cleared by clr.
- overrun  output  N_CH  sticky: a pulse occurred while event_flag was already set.

Behaviour:
- Reset (rstN low, asynchronous):
  - All synchronizer flops, debounce counters and repeat counters go to 0.
  - level, pulse, event_flag and overrun all read 0.
- Reset release with an input held high: after the normal latency this is seen as a rising edge and pulses in modes 00/10.
- Synchronizer: SYNC_STAGES-deep shift chain per channel; s = last stage.
- Debounce, per channel, counter width clog2(DEBOUNCE_CYCLES+1):
  - If s == level: counter is cleared to 0.
  - If s != level: counter increments.
  - When s != level and counter == max(DEBOUNCE_CYCLES,1)-1: level <= s and counter is cleared.
  - A glitch shorter than DEBOUNCE_CYCLES clears the counter and never changes level.
- Latency: the first clk edge sampling a new, stable input value is edge 1. level changes at edge SYNC_STAGES+max(DEBOUNCE_CYCLES,1).
- Edge detect:
  - pulse is registered and asserts on the same edge level changes, for exactly one cycle.
  - Rise = level 0->1; fall = 1->0; both = either.
  - Mode 11: pulse stays 0, while level still tracks the input.
  - Mode is sampled on the cycle level changes; a mode change never creates a pulse.
- Flags, per channel, evaluated on the same edge as pulse:
  - Pulse with event_flag=0: event_flag <= 1.
  - Pulse with event_flag=1 and clr=0: overrun <= 1, event_flag stays 1.
  - Simultaneous pulse and clr: set wins. event_flag <= 1, overrun <= 0, because the flag was consumed this cycle.
  - clr alone: event_flag <= 0, overrun <= 0.
- Channels are fully independent; there is no shared state except clk/rstN.

Optional Feature:
- Macro: EDGE_PULSE_AUTOREPEAT_EN.
- Defined: each channel gets a repeat counter, active while level=1 and mode is 00 or 10.
  - The counter starts on the rising level.
  - An extra pulse fires at REPEAT_DELAY cycles after the rising-edge pulse, then every REPEAT_PERIOD cycles.
  - Repeat pulses set event_flag/overrun exactly like edge pulses.
  - The counter clears when level falls or mode goes to 01/11.
  - A falling-edge pulse in mode 10 is unaffected.
- Undefined: no repeat logic is synthesized; REPEAT_DELAY and REPEAT_PERIOD are ignored; pulse comes only from edges.

Test Plan:
- Rise, clean: N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=16, mode=00, in[0] 0->1 held.
  - level[0] and pulse[0] rise at edge 18; pulse[0] is high for exactly 1 cycle; event_flag[0]=1 from edge 18.
- Glitch: in[1] high for 10 cycles, then low.
  - level[1], pulse[1] and event_flag[1] stay 0.
  - Repeat with a 16-cycle glitch: level[1] rises at edge 18.
- Both-edge mode:
  - mode[5:4]=10, in[2] pulsed high for 40 cycles: two pulses, about 40 cycles apart.
  - Same stimulus with mode 01: one pulse, on the fall only.
  - Same stimulus with mode 11: no pulse, while level[2] still toggles.
- Flags:
  - Two rising edges on ch3 with no clr: event_flag[3]=1, overrun[3]=1.
  - clr[3] for one cycle: both flags go to 0.
  - clr[3] on the same cycle as a pulse: event_flag=1, overrun=0.
- Reset mid-operation:
  - Drop rstN while ch0's counter is at 8: all outputs go to 0 immediately.
  - Release with in[0]=1: rising pulse at edge 18 after release.
- Auto-repeat, with the macro defined: REPEAT_DELAY=20, REPEAT_PERIOD=5, DEBOUNCE_CYCLES=2, in held high 40 cycles.
  - Pulses at t0, t0+20, t0+25, t0+30, ... until level falls; no pulses after the fall in mode 00.

Source files
------------

// File: rtl/edge_pulse_bank_if.sv
// Channel bus for edge_pulse_bank: raw inputs, per-channel mode/clear, and the
// debounced level, edge pulse and sticky flag outputs.
interface edge_pulse_bank_if #(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0]   in;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   clr;
  logic [N_CH-1:0]   pulse;
  logic [N_CH-1:0]   level;
  logic [N_CH-1:0]   event_flag;
  logic [N_CH-1:0]   overrun;

  modport master (
    output in, mode, clr,
    input  pulse, level, event_flag, overrun
  );

  modport slave (
    input  in, mode, clr,
    output pulse, level, event_flag, overrun
  );
endinterface

// File: rtl/edge_pulse_bank.sv
// Multi-channel synchronizer + debouncer + edge-to-pulse converter with sticky
// event/overrun flags. Define EDGE_PULSE_AUTOREPEAT_EN to add held-key auto-repeat.
module edge_pulse_bank #(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 1000,
  parameter int unsigned REPEAT_PERIOD   = 250
) (
  input  logic                  clk,
  input  logic                  rstN,
  edge_pulse_bank_if.slave      bus
);

  localparam int unsigned DB_EFF = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 1;
  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DB_EFF - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("edge_pulse_bank: SYNC_STAGES must be 2..4");
  end
  if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_rpt
    $error("edge_pulse_bank: REPEAT_DELAY and REPEAT_PERIOD must be nonzero");
  end

  logic [SYNC_STAGES-1:0] sync_q   [N_CH];
  logic [CNT_W-1:0]       db_cnt_q [N_CH];
  logic [CNT_W-1:0]       db_cnt_d [N_CH];
  logic [N_CH-1:0]        level_q, level_d;
  logic [N_CH-1:0]        edge_hit, rpt_hit, pulse_d, pulse_q;
  logic [N_CH-1:0]        flag_q, flag_d, ovr_q, ovr_d;
  logic [1:0]             ch_mode;
  logic                   s_cur;

  // Debounce on the synchronized level and qualify the resulting edge by mode
  always_comb begin : p_debounce
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    edge_hit = '0;
    ch_mode  = 2'b00;
    s_cur    = 1'b0;
    for (int i = 0; i < int'(N_CH); i++) begin
      s_cur   = sync_q[i][SYNC_STAGES-1];
      ch_mode = bus.mode[2*i +: 2];
      if (s_cur == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_TERM) begin
        level_d[i]  = s_cur;
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
      if (level_d[i] != level_q[i]) begin
        case (ch_mode)
          2'b00:   edge_hit[i] = s_cur;
          2'b01:   edge_hit[i] = ~s_cur;
          2'b10:   edge_hit[i] = 1'b1;
          default: edge_hit[i] = 1'b0;
        endcase
      end
    end
  end

`ifdef EDGE_PULSE_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q [N_CH];
  logic [RPT_W-1:0] rpt_cnt_d [N_CH];
  logic [N_CH-1:0]  rpt_run_q, rpt_run_d;
  logic [RPT_W-1:0] rpt_target, rpt_next;

  // Held-high repeat: first interval is the delay, later ones the period.
  // Mode bit 0 clear means rise or both. No repeat fires on the falling edge.
  always_comb begin : p_repeat
    rpt_cnt_d  = rpt_cnt_q;
    rpt_run_d  = rpt_run_q;
    rpt_hit    = '0;
    rpt_target = '0;
    rpt_next   = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      rpt_target = rpt_run_q[i] ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);
      rpt_next   = rpt_cnt_q[i] + RPT_W'(1);
      if (level_q[i] && !bus.mode[2*i]) begin
        if (rpt_next == rpt_target) begin
          rpt_hit[i]   = level_d[i];
          rpt_cnt_d[i] = '0;
          rpt_run_d[i] = 1'b1;
        end else begin
          rpt_cnt_d[i] = rpt_next;
        end
      end else begin
        rpt_cnt_d[i] = '0;
        rpt_run_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin : p_repeat_q
    if (!rstN) begin
      for (int i = 0; i < int'(N_CH); i++) rpt_cnt_q[i] <= '0;
      rpt_run_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_run_q <= rpt_run_d;
    end
  end
`else
  assign rpt_hit = '0;
`endif

  // Sticky flags: a pulse always sets the event flag; clr with a pulse drops overrun
  always_comb begin : p_flags
    pulse_d = edge_hit | rpt_hit;
    flag_d  = flag_q;
    ovr_d   = ovr_q;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (pulse_d[i]) begin
        flag_d[i] = 1'b1;
        ovr_d[i]  = ~bus.clr[i] & (ovr_q[i] | flag_q[i]);
      end else if (bus.clr[i]) begin
        flag_d[i] = 1'b0;
        ovr_d[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin : p_state
    if (!rstN) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        sync_q[i]   <= '0;
        db_cnt_q[i] <= '0;
      end
      level_q <= '0;
      pulse_q <= '0;
      flag_q  <= '0;
      ovr_q   <= '0;
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.in[i]};
      end
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      flag_q   <= flag_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.pulse      = pulse_q;
  assign bus.level      = level_q;
  assign bus.event_flag = flag_q;
  assign bus.overrun    = ovr_q;

endmodule
